// File: rtl/multi_fifo_rr_drain_if.sv
// ---------------------------------------------------------------------------
// multi_fifo_rr_drain_if
//   Valid/ready word stream that carries one drained FIFO word plus the
//   index of the channel it came from.
//
//   Signals
//     valid  word on data/ch is valid (driven by the master)
//     ready  sink accepts the word this cycle (driven by the slave)
//     data   DATA_WIDTH-bit word
//     ch     CH_W-bit source channel of data
//
//   Modports
//     master  drain scheduler side
//     slave   downstream consumer side
// ---------------------------------------------------------------------------
interface multi_fifo_rr_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = 2
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CH_W-1:0]       ch;

  modport master (output valid, output data, output ch, input ready);
  modport slave  (input valid, input data, input ch, output ready);
endinterface

// File: rtl/multi_fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// multi_fifo_rr_drain
//   Round-robin read scheduler and sole reader of a multi-FIFO bank. It picks
//   an eligible FIFO (enabled and non-empty), pops up to BURST_LEN words from
//   it one at a time and presents each word, tagged with its channel, on a
//   valid/ready stream. The grant then rotates to the next eligible channel.
//
//   Per word the FSM walks RD (pop) -> CAP (capture DOUT) -> OUT (handshake);
//   ARB is only visited when a new grant is needed.
//
//   Ports
//     clk         system clock
//     rst_n       asynchronous active-low reset
//     fifo_empty  per-FIFO EMPTY flags from the bank
//     fifo_dout   bank read data, channel i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//     fifo_rd_en  one-hot registered read enables to the bank
//     ch_en       per-channel enable mask
//     stream      output word stream (master side)
//     busy        high whenever the FSM is outside ARB
// ---------------------------------------------------------------------------
module multi_fifo_rr_drain #(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int CH_W      = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_FIFOS-1:0]            fifo_rd_en,
  input  logic [NUM_FIFOS-1:0]            ch_en,
  multi_fifo_rr_drain_if.master           stream,
  output logic                            busy
);

  typedef enum logic [1:0] {
    ARB = 2'd0,
    RD  = 2'd1,
    CAP = 2'd2,
    OUT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FIFOS-1:0]  rd_en_q, rd_en_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]            burst_q, burst_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d;

  logic [NUM_FIFOS-1:0]  eligible;
  logic                  found;
  logic [CH_W-1:0]       pick;
  logic                  burst_more;
  int                    idx;

  // Round-robin search: first eligible channel strictly after rr_ptr,
  // wrapping around, so the last-served channel is considered last.
  // NOTE: every variable written here gets a default before the loop;
  // otherwise a path that leaves it unassigned would infer a latch.
  always_comb begin
    eligible = ch_en & ~fifo_empty;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  // Burst continuation is decided on the granted channel's live flags; the
  // word just handed off was already popped, so EMPTY reflects what remains.
  assign burst_more = (burst_q < 8'(BURST_LEN)) && ch_en[grant_q] && !fifo_empty[grant_q];

  always_comb begin
    state_d  = state_q;
    rd_en_d  = '0;          // read strobe is a single-cycle pulse by default
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ch_d     = ch_q;

    unique case (state_q)
      ARB: begin
        if (found) begin
          grant_d = pick;
          rd_en_d = NUM_FIFOS'(1) << pick;
          burst_d = 8'd1;
          state_d = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        // The bank presents the popped word from the cycle after RD.
        data_d  = fifo_dout[grant_q*DATA_WIDTH +: DATA_WIDTH];
        ch_d    = grant_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (valid_q && stream.ready) begin
          valid_d = 1'b0;
          if (burst_more) begin
            rd_en_d = NUM_FIFOS'(1) << grant_q;
            burst_d = burst_q + 8'd1;
            state_d = RD;
          end else begin
            rr_ptr_d = grant_q;
            state_d  = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      rd_en_q  <= '0;
      grant_q  <= '0;
      rr_ptr_q <= CH_W'(NUM_FIFOS - 1);   // first grant searches from channel 0
      burst_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
    end
  end

  assign fifo_rd_en   = rd_en_q;
  assign stream.valid = valid_q;
  assign stream.data  = data_q;
  assign stream.ch    = ch_q;
  assign busy         = (state_q != ARB);

endmodule

// File: tb/tb_multi_fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// tb_multi_fifo_rr_drain
//   Bench for multi_fifo_rr_drain (NUM_FIFOS=4, DATA_WIDTH=8, BURST_LEN=2).
//   A queue-based FIFO bank feeds the DUT. A transaction-level model turns
//   loaded words into the expected (channel, word) sequence; one compare
//   process checks every handshake against it plus per-cycle invariants.
//   Directed tests add hand-computed timing and state expectations.
// ---------------------------------------------------------------------------
module tb_multi_fifo_rr_drain;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int BL  = 2;
  localparam int CHW = 2;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
  } word_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    fifo_empty = '1;
  logic [N*DW-1:0] fifo_dout;
  logic [N-1:0]    fifo_rd_en;
  logic [N-1:0]    ch_en = '1;
  logic            busy;

  logic [DW-1:0]   dout_r [N] = '{default: '0};
  logic [DW-1:0]   bank_q [N][$];
  logic [DW-1:0]   mdl_q  [N][$];
  int              mdl_ptr = N - 1;
  word_t           exp_q[$];
  int              hs_cyc[$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_errors = 0;

  logic            stall_prev = 1'b0;
  logic [DW-1:0]   prev_data  = '0;
  logic [CHW-1:0]  prev_ch    = '0;

  multi_fifo_rr_drain_if #(.DATA_WIDTH(DW), .CH_W(CHW)) stream ();

  multi_fifo_rr_drain #(
    .NUM_FIFOS (N),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .ch_en     (ch_en),
    .stream    (stream),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO bank: pop on RD_EN, word on DOUT the next cycle ---
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      if (fifo_rd_en[i] && bank_q[i].size() != 0) dout_r[i] <= bank_q[i].pop_front();
    for (int i = 0; i < N; i++) fifo_empty[i] <= (bank_q[i].size() == 0);
  end

  always_comb begin
    fifo_dout = '0;
    for (int i = 0; i < N; i++) fifo_dout[i*DW +: DW] = dout_r[i];
  end

  // ---------------- transaction-level model -------------------------------
  // Grants rotate from the channel after the last grant; each grant takes up
  // to BL words from one enabled, non-empty channel.
  task automatic run_model(input logic [N-1:0] en);
    int    g;
    word_t w;
    do begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mdl_ptr + k) % N;
        if (g < 0 && en[c] && mdl_q[c].size() > 0) g = c;
      end
      if (g >= 0) begin
        for (int b = 0; b < BL && mdl_q[g].size() > 0; b++) begin
          w.ch   = CHW'(g);
          w.data = mdl_q[g].pop_front();
          exp_q.push_back(w);
        end
        mdl_ptr = g;
      end
    end while (g >= 0);
  endtask

  task automatic load(input int ch, input logic [DW-1:0] d, input bit to_model);
    bank_q[ch].push_back(d);
    if (to_model) mdl_q[ch].push_back(d);
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d);
    word_t w;
    w.ch   = CHW'(ch);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || stream.valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd(input int ch, input string name);
    int n;
    n = 0;
    while (!fifo_rd_en[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rd_seen"}, {31'd0, fifo_rd_en[ch]}, 32'd1);
  endtask

  // ---------------- compare process ---------------------------------------
  always @(negedge clk) begin
    word_t w;
    #1;
    check("rd_en_onehot0", {31'd0, $onehot0(fifo_rd_en)}, 32'd1);
    if (!rst_n) begin
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_valid", {31'd0, stream.valid}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      stall_prev <= 1'b0;
    end else begin
      check("rd_en_while_valid", 32'(fifo_rd_en & {N{stream.valid}}), 32'd0);
      check("rd_en_on_empty",    32'(fifo_rd_en & fifo_empty), 32'd0);
      check("valid_implies_busy", {31'd0, stream.valid & ~busy}, 32'd0);
      if (stall_prev) begin
        check("stall_valid", {31'd0, stream.valid}, 32'd1);
        check("stall_data",  32'(stream.data), 32'(prev_data));
        check("stall_ch",    32'(stream.ch), 32'(prev_ch));
      end
      if (stream.valid && stream.ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          w = exp_q.pop_front();
          check("out_ch",   32'(stream.ch), 32'(w.ch));
          check("out_data", 32'(stream.data), 32'(w.data));
        end
      end
      stall_prev <= stream.valid && !stream.ready;
      prev_data  <= stream.data;
      prev_ch    <= stream.ch;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------------------------------
  initial begin
    stream.ready = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: everything empty, all channels enabled.
    repeat (20) begin
      @(negedge clk);
      check("idle_busy",  {31'd0, busy}, 32'd0);
      check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      check("idle_valid", {31'd0, stream.valid}, 32'd0);
    end

    // Single channel: FIFO2 holds A1,A2,A3.
    hs_cyc.delete();
    load(2, 8'hA1, 1'b1);
    load(2, 8'hA2, 1'b1);
    load(2, 8'hA3, 1'b1);
    run_model(ch_en);
    check("mdl_t2_size", 32'(exp_q.size()), 32'd3);
    check("mdl_t2_last", 32'(exp_q[2]), {22'd0, 2'd2, 8'hA3});
    @(negedge clk);                       // EMPTY[2] just fell; ARB sees it this cycle
    check("t2_rd_en_arb", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    check("t2_rd_en_rd", 32'(fifo_rd_en), 32'b0100);
    check("t2_busy_rd", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_rd_en_cap", 32'(fifo_rd_en), 32'd0);
    check("t2_valid_cap", {31'd0, stream.valid}, 32'd0);
    @(negedge clk);
    check("t2_valid_out", {31'd0, stream.valid}, 32'd1);
    check("t2_ch_out",    32'(stream.ch), 32'd2);
    check("t2_data_out",  32'(stream.data), 32'hA1);
    wait_idle("t2");
    check("t2_handshakes", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("t2_burst_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      check("t2_regrant_spacing", 32'(hs_cyc[2] - hs_cyc[1]), 32'd4);
    end

    // All four FIFOs, 8 words each, ready held high.
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 8; k++) load(c, 8'(c * 16 + k), 1'b1);
    run_model(ch_en);
    check("mdl_t3_size", 32'(exp_q.size()), 32'd32);
    check("mdl_t3_ch0",  32'(exp_q[0].ch), 32'd3);
    check("mdl_t3_ch2",  32'(exp_q[2].ch), 32'd0);
    check("mdl_t3_ch31", 32'(exp_q[31].ch), 32'd2);
    wait_idle("t3");

    // Same load with a 10-cycle downstream stall.
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 8; k++) load(c, 8'(128 + c * 16 + k), 1'b1);
    run_model(ch_en);
    begin
      int n;
      n = 0;
      while (!stream.valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t4_valid_seen", {31'd0, stream.valid}, 32'd1);
    end
    stream.ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_stall_valid", {31'd0, stream.valid}, 32'd1);
    check("t4_stall_rd_en", 32'(fifo_rd_en), 32'd0);
    stream.ready = 1'b1;
    wait_idle("t4");

    // Channel 1 masked.
    ch_en = 4'b1101;
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 4; k++) load(c, 8'(64 + c * 16 + k), 1'b1);
    run_model(ch_en);
    check("mdl_t5_size", 32'(exp_q.size()), 32'd12);
    check("mdl_t5_ch0",  32'(exp_q[0].ch), 32'd3);
    check("mdl_t5_ch2",  32'(exp_q[2].ch), 32'd0);
    check("mdl_t5_ch4",  32'(exp_q[4].ch), 32'd2);
    wait_idle("t5");
    check("t5_ch1_untouched", 32'(bank_q[1].size()), 32'd4);
    ch_en = 4'hF;
    run_model(ch_en);
    wait_idle("t5_flush");

    // Channel 2 disabled mid-burst: B1 completes, grant moves to 3, B2 waits.
    load(2, 8'hB1, 1'b0);
    load(2, 8'hB2, 1'b0);
    load(3, 8'hC1, 1'b0);
    load(3, 8'hC2, 1'b0);
    push_exp(2, 8'hB1);
    push_exp(3, 8'hC1);
    push_exp(3, 8'hC2);
    push_exp(2, 8'hB2);
    wait_rd(2, "t6");
    ch_en = 4'b1011;
    begin
      int n;
      n = 0;
      while (exp_q.size() > 1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (4) @(negedge clk);
    check("t6_parked_words", 32'(exp_q.size()), 32'd1);
    check("t6_parked_busy",  {31'd0, busy}, 32'd0);
    check("t6_parked_rd_en", 32'(fifo_rd_en), 32'd0);
    ch_en = 4'hF;
    wait_idle("t6");
    mdl_ptr = 2;

    // Reset during CAP, then restart from channel 0.
    load(3, 8'hE1, 1'b0);
    wait_rd(3, "t7");
    @(negedge clk);
    check("t7_busy_cap", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_async_busy",  {31'd0, busy}, 32'd0);
    check("t7_async_valid", {31'd0, stream.valid}, 32'd0);
    check("t7_async_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(0, 8'hF1, 1'b0);
    load(3, 8'hD3, 1'b0);
    push_exp(0, 8'hF1);
    push_exp(3, 8'hD3);
    begin
      int n;
      n = 0;
      while (fifo_rd_en == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t7_first_grant", 32'(fifo_rd_en), 32'b0001);
    end
    wait_idle("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
